// File: rtl/mat_mul_pkg.sv
// Shared types and timing helpers for the systolic matrix-multiply controller,
// array wrapper and bench.
package mat_mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam int unsigned DATA_W = 8;

    // Cycles of zero feed needed to flush the skewed wavefront out of the array.
    function automatic int unsigned drain_len(input int unsigned m);
        return 2 * m - 1;
    endfunction

    // Cycles from the start-sampling edge to the capture/done cycle.
    function automatic int unsigned total_latency(input int unsigned m);
        return 3 * m + 1;
    endfunction

endpackage

// File: rtl/mat_mul_ctrl_step_counter.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
module step_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    input  logic [Width-1:0] term_val,
    output logic [Width-1:0] count,
    output logic             at_term
);

    logic [Width-1:0] count_d, count_q;

    // Clear wins over load, load wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_term = (count_q == term_val);

endmodule

// File: rtl/mat_mul_ctrl.sv
// Sequencer for one MxM systolic multiply: clear, stream M operand vectors,
// drain the skewed wavefront with zero feeds, then capture and report done.
module mat_mul_ctrl
    import mat_mul_pkg::*;
#(
    parameter int unsigned M = 3,
    parameter int unsigned W = DATA_W
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W-1:0]         a_col   [0:M-1],
    input  logic [W-1:0]         b_row   [0:M-1],
    output logic [$clog2(M)-1:0] k_idx,
    output logic [W-1:0]         a_feed  [0:M-1],
    output logic [W-1:0]         b_feed  [0:M-1],
    output logic                 acc_clr,
    output logic                 capture,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned KW = $clog2(M);
    // Wide enough for the longest phase (2M-1 drain cycles) without wrapping.
    localparam int unsigned CW = $clog2(2 * M - 1);

    localparam logic [CW-1:0] StreamLast = CW'(M - 1);
    localparam logic [CW-1:0] DrainLast  = CW'(2 * M - 2);

    ctrl_state_t state_d, state_q;

    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_term;
    logic          cnt_at_term;
    logic          feed_en;

    // One counter serves both phases; its terminal value follows the state.
    assign cnt_term = (state_q == DRAIN) ? DrainLast : StreamLast;

    step_counter #(
        .Width (CW)
    ) u_step_counter (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (cnt_en),
        .term_val (cnt_term),
        .count    (cnt),
        .at_term  (cnt_at_term)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (cnt_at_term) begin
                    cnt_clr = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_at_term) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
        // Abort overrides every transition, including DONE and a start in IDLE.
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        acc_clr = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        feed_en = 1'b0;
        k_idx   = '0;
        unique case (state_q)
            IDLE:    ;
            CLEAR:   acc_clr = 1'b1;
            STREAM: begin
                feed_en = 1'b1;
                k_idx   = KW'(cnt);
            end
            DRAIN:   ;
            DONE: begin
                capture = 1'b1;
                done    = 1'b1;
            end
            default: busy = 1'b0;
        endcase
        // Zero feeds outside STREAM keep the draining accumulators undisturbed.
        for (int i = 0; i < M; i++) begin
            a_feed[i] = feed_en ? a_col[i] : '0;
            b_feed[i] = feed_en ? b_row[i] : '0;
        end
    end

endmodule
